alu_sequencer: RTL and testbench

Command-driven controller for the 16-bit six-control-bit ALU (zx, nx, zy, ny, f, no → o, zr, ng). It accepts one operation at a time over a valid/ready command port and drives the ALU control word from an opcode ROM. It sequences a multi-cycle shift-add multiply using the ALU as its only adder, then returns the result over a valid/ready response port. It sits between the instruction/issue logic and the ALU, which it instantiates.

---
 rtl/alu_seq_pkg.sv | 94 +++++++++
 rtl/alu_seq_alu.sv | 35 +++
 rtl/alu_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, ALU control words,
// sequencer states and the opcode-to-control-word ROM.
package alu_seq_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 5;
    localparam int CTRL_W = 6;

    // Opcodes, in ROM order.
    localparam logic [OP_W-1:0] OP_ZERO    = 5'd0;
    localparam logic [OP_W-1:0] OP_ONE     = 5'd1;
    localparam logic [OP_W-1:0] OP_NEG_ONE = 5'd2;
    localparam logic [OP_W-1:0] OP_X       = 5'd3;
    localparam logic [OP_W-1:0] OP_Y       = 5'd4;
    localparam logic [OP_W-1:0] OP_NOT_X   = 5'd5;
    localparam logic [OP_W-1:0] OP_NOT_Y   = 5'd6;
    localparam logic [OP_W-1:0] OP_NEG_X   = 5'd7;
    localparam logic [OP_W-1:0] OP_NEG_Y   = 5'd8;
    localparam logic [OP_W-1:0] OP_X_INC   = 5'd9;
    localparam logic [OP_W-1:0] OP_Y_INC   = 5'd10;
    localparam logic [OP_W-1:0] OP_X_DEC   = 5'd11;
    localparam logic [OP_W-1:0] OP_Y_DEC   = 5'd12;
    localparam logic [OP_W-1:0] OP_ADD     = 5'd13;
    localparam logic [OP_W-1:0] OP_X_SUB_Y = 5'd14;
    localparam logic [OP_W-1:0] OP_Y_SUB_X = 5'd15;
    localparam logic [OP_W-1:0] OP_AND     = 5'd16;
    localparam logic [OP_W-1:0] OP_OR      = 5'd17;
    localparam logic [OP_W-1:0] OP_MUL     = 5'd18;

    // ALU control words {zx, nx, zy, ny, f, no}.
    localparam logic [CTRL_W-1:0] CTRL_ZERO    = 6'b101010;
    localparam logic [CTRL_W-1:0] CTRL_ONE     = 6'b111111;
    localparam logic [CTRL_W-1:0] CTRL_NEG_ONE = 6'b111010;
    localparam logic [CTRL_W-1:0] CTRL_X       = 6'b001100;
    localparam logic [CTRL_W-1:0] CTRL_Y       = 6'b110000;
    localparam logic [CTRL_W-1:0] CTRL_NOT_X   = 6'b001101;
    localparam logic [CTRL_W-1:0] CTRL_NOT_Y   = 6'b110001;
    localparam logic [CTRL_W-1:0] CTRL_NEG_X   = 6'b001111;
    localparam logic [CTRL_W-1:0] CTRL_NEG_Y   = 6'b110011;
    localparam logic [CTRL_W-1:0] CTRL_X_INC   = 6'b011111;
    localparam logic [CTRL_W-1:0] CTRL_Y_INC   = 6'b110111;
    localparam logic [CTRL_W-1:0] CTRL_X_DEC   = 6'b001110;
    localparam logic [CTRL_W-1:0] CTRL_Y_DEC   = 6'b110010;
    localparam logic [CTRL_W-1:0] CTRL_ADD     = 6'b000010;
    localparam logic [CTRL_W-1:0] CTRL_X_SUB_Y = 6'b010011;
    localparam logic [CTRL_W-1:0] CTRL_Y_SUB_X = 6'b000111;
    localparam logic [CTRL_W-1:0] CTRL_AND     = 6'b000000;
    localparam logic [CTRL_W-1:0] CTRL_OR      = 6'b010101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL_DBL,
        ST_MUL_ADD,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic              legal;
        logic [CTRL_W-1:0] ctrl;
    } op_dec_t;

    // Opcode ROM. MUL reports legal with the adder control word; whether
    // MUL is actually enabled is decided by the instantiating block.
    function automatic op_dec_t op2ctrl(input logic [OP_W-1:0] op);
        op_dec_t dec;
        dec.legal = 1'b1;
        dec.ctrl  = CTRL_ZERO;
        case (op)
            OP_ZERO:    dec.ctrl = CTRL_ZERO;
            OP_ONE:     dec.ctrl = CTRL_ONE;
            OP_NEG_ONE: dec.ctrl = CTRL_NEG_ONE;
            OP_X:       dec.ctrl = CTRL_X;
            OP_Y:       dec.ctrl = CTRL_Y;
            OP_NOT_X:   dec.ctrl = CTRL_NOT_X;
            OP_NOT_Y:   dec.ctrl = CTRL_NOT_Y;
            OP_NEG_X:   dec.ctrl = CTRL_NEG_X;
            OP_NEG_Y:   dec.ctrl = CTRL_NEG_Y;
            OP_X_INC:   dec.ctrl = CTRL_X_INC;
            OP_Y_INC:   dec.ctrl = CTRL_Y_INC;
            OP_X_DEC:   dec.ctrl = CTRL_X_DEC;
            OP_Y_DEC:   dec.ctrl = CTRL_Y_DEC;
            OP_ADD:     dec.ctrl = CTRL_ADD;
            OP_X_SUB_Y: dec.ctrl = CTRL_X_SUB_Y;
            OP_Y_SUB_X: dec.ctrl = CTRL_Y_SUB_X;
            OP_AND:     dec.ctrl = CTRL_AND;
            OP_OR:      dec.ctrl = CTRL_OR;
            OP_MUL:     dec.ctrl = CTRL_ADD;
            default:    dec.legal = 1'b0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// Combinational six-control-bit ALU: optional zero/negate of each input,
// add or AND, optional negate of the result, plus zero/negative flags.
module alu_seq_alu
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0]  i_x,
    input  logic [WIDTH-1:0]  i_y,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic [WIDTH-1:0]  o_out,
    output logic              o_zr,
    output logic              o_ng
);

    logic             w_zx, w_nx, w_zy, w_ny, w_f, w_no;
    logic [WIDTH-1:0] w_x0, w_x1, w_y0, w_y1, w_fn;

    assign {w_zx, w_nx, w_zy, w_ny, w_f, w_no} = i_ctrl;

    // Input conditioning, function select and output negate; the adder
    // is exactly WIDTH bits wide so the carry out of the top bit is dropped.
    always_comb begin
        w_x0  = w_zx ? '0 : i_x;
        w_x1  = w_nx ? ~w_x0 : w_x0;
        w_y0  = w_zy ? '0 : i_y;
        w_y1  = w_ny ? ~w_y0 : w_y0;
        w_fn  = w_f ? (w_x1 + w_y1) : (w_x1 & w_y1);
        o_out = w_no ? ~w_fn : w_fn;
    end

    assign o_zr = (o_out == '0);
    assign o_ng = o_out[WIDTH-1];

endmodule

// File: rtl/alu_sequencer.sv
// Command-driven ALU controller. Single operations take one EXEC cycle;
// MUL is a left-to-right shift-add over the multiplier bits, using the
// ALU adder for both the doubling and the partial-product add.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_x,
    input  logic [WIDTH-1:0] cmd_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zr,
    output logic             rsp_ng,
    output logic             rsp_err,
    output logic             busy
);

    localparam int IDX_W = $clog2(WIDTH);

    state_t            r_state, w_next;
    logic [OP_W-1:0]   r_op;
    logic [WIDTH-1:0]  r_x, r_y, r_acc;
    logic [IDX_W-1:0]  r_idx;
    logic [WIDTH-1:0]  r_data;
    logic              r_zr, r_ng, r_err;

    op_dec_t           w_dec;
    logic              w_legal;
    logic              w_accept;
    logic              w_mul_cmd;
    logic              w_last_bit;
    logic              w_cur_bit;
    logic [WIDTH-1:0]  w_alu_x, w_alu_y, w_alu_o;
    logic [CTRL_W-1:0] w_alu_ctrl;
    logic              w_alu_zr, w_alu_ng;

    assign w_dec      = op2ctrl(r_op);
    assign w_legal    = w_dec.legal && ((r_op != OP_MUL) || (MUL_EN != 0));
    assign w_accept   = cmd_valid && (r_state == ST_IDLE);
    assign w_mul_cmd  = (MUL_EN != 0) && (cmd_op == OP_MUL);
    assign w_last_bit = (r_idx == '0);
    assign w_cur_bit  = r_y[r_idx];

    alu_seq_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_x    (w_alu_x),
        .i_y    (w_alu_y),
        .i_ctrl (w_alu_ctrl),
        .o_out  (w_alu_o),
        .o_zr   (w_alu_zr),
        .o_ng   (w_alu_ng)
    );

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and ALU input steering.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case leaves a signal unassigned and infers a latch.
        w_next     = r_state;
        w_alu_x    = '0;
        w_alu_y    = '0;
        w_alu_ctrl = CTRL_ZERO;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_mul_cmd ? ST_MUL_DBL : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_legal) begin
                    w_alu_x    = r_x;
                    w_alu_y    = r_y;
                    w_alu_ctrl = w_dec.ctrl;
                end
                w_next = ST_RESP;
            end
            ST_MUL_DBL: begin
                w_alu_x    = r_acc;
                w_alu_y    = r_acc;
                w_alu_ctrl = CTRL_ADD;
                if (w_cur_bit) begin
                    w_next = ST_MUL_ADD;
                end else if (w_last_bit) begin
                    w_next = ST_RESP;
                end
            end
            ST_MUL_ADD: begin
                w_alu_x    = r_acc;
                w_alu_y    = r_x;
                w_alu_ctrl = CTRL_ADD;
                w_next     = w_last_bit ? ST_RESP : ST_MUL_DBL;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand capture, multiply accumulator/bit index and result registers.
    // NOTE: the result registers are reset as well, so the response port
    // reads a defined value before the first command completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_acc  <= '0;
            r_idx  <= '0;
            r_data <= '0;
            r_zr   <= 1'b0;
            r_ng   <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= cmd_op;
                        r_x   <= cmd_x;
                        r_y   <= cmd_y;
                        r_acc <= '0;
                        r_idx <= IDX_W'(WIDTH - 1);
                    end
                end
                ST_EXEC: begin
                    r_data <= w_legal ? w_alu_o : '0;
                    r_zr   <= w_legal ? w_alu_zr : 1'b1;
                    r_ng   <= w_legal ? w_alu_ng : 1'b0;
                    r_err  <= !w_legal;
                end
                ST_MUL_DBL: begin
                    r_acc <= w_alu_o;
                    if (!w_cur_bit) begin
                        if (w_last_bit) begin
                            r_data <= w_alu_o;
                            r_zr   <= w_alu_zr;
                            r_ng   <= w_alu_ng;
                            r_err  <= 1'b0;
                        end else begin
                            r_idx <= r_idx - 1'b1;
                        end
                    end
                end
                ST_MUL_ADD: begin
                    r_acc <= w_alu_o;
                    if (w_last_bit) begin
                        r_data <= w_alu_o;
                        r_zr   <= w_alu_zr;
                        r_ng   <= w_alu_ng;
                        r_err  <= 1'b0;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = r_data;
    assign rsp_zr    = r_zr;
    assign rsp_ng    = r_ng;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a transaction-level reference
// model checked every cycle, plus directed vectors with literal results.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_op;
    logic [15:0] cmd_x, cmd_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_zr, rsp_ng, rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_sequencer #(
        .WIDTH  (16),
        .MUL_EN (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zr    (rsp_zr),
        .rsp_ng    (rsp_ng),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result of one command: plain arithmetic on the operands.
    typedef struct {
        logic [15:0] data;
        logic        err;
    } ref_t;

    function automatic ref_t ref_op(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
        ref_t        r;
        logic [31:0] prod;
        prod   = 32'(x) * 32'(y);
        r.err  = 1'b0;
        r.data = 16'h0000;
        case (op)
            5'd0:  r.data = 16'd0;
            5'd1:  r.data = 16'd1;
            5'd2:  r.data = 16'hFFFF;
            5'd3:  r.data = x;
            5'd4:  r.data = y;
            5'd5:  r.data = ~x;
            5'd6:  r.data = ~y;
            5'd7:  r.data = 16'd0 - x;
            5'd8:  r.data = 16'd0 - y;
            5'd9:  r.data = x + 16'd1;
            5'd10: r.data = y + 16'd1;
            5'd11: r.data = x - 16'd1;
            5'd12: r.data = y - 16'd1;
            5'd13: r.data = x + y;
            5'd14: r.data = x - y;
            5'd15: r.data = y - x;
            5'd16: r.data = x & y;
            5'd17: r.data = x | y;
            5'd18: r.data = prod[15:0];
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    // Transaction-level model: idle / busy for a latency count / responding.
    typedef enum {M_IDLE, M_BUSY, M_RESP} mphase_t;
    mphase_t     m_phase;
    int          m_left;
    logic [15:0] m_data;
    logic        m_err;
    logic        cmp_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = M_IDLE;
            m_left  = 0;
            m_data  = 16'h0000;
            m_err   = 1'b0;
        end else begin
            case (m_phase)
                M_IDLE: if (cmd_valid) begin
                    ref_t r;
                    r       = ref_op(cmd_op, cmd_x, cmd_y);
                    m_data  = r.data;
                    m_err   = r.err;
                    m_left  = ((cmd_op == 5'd18) ? (17 + $countones(cmd_y)) : 2) - 1;
                    m_phase = M_BUSY;
                end
                M_BUSY: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = M_RESP;
                end
                M_RESP: if (rsp_ready) m_phase = M_IDLE;
                default: m_phase = M_IDLE;
            endcase
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_phase == M_IDLE});
            check("busy", {31'd0, busy}, {31'd0, m_phase != M_IDLE});
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_phase == M_RESP});
            if (m_phase == M_RESP) begin
                check("model_data", {16'd0, rsp_data}, {16'd0, m_data});
                check("model_zr", {31'd0, rsp_zr}, {31'd0, m_data == 16'd0});
                check("model_ng", {31'd0, rsp_ng}, {31'd0, m_data[15]});
                check("model_err", {31'd0, rsp_err}, {31'd0, m_err});
            end
        end
    end

    // Issue one command, wait for its response, optionally stall the
    // response for 'hold' cycles (with a stray command pulse), then accept it.
    task automatic run_op(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y,
                          input int hold, output logic [15:0] d, output logic zr,
                          output logic ng, output logic err, output int lat);
        int n;
        @(negedge clk);
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        d = rsp_data; zr = rsp_zr; ng = rsp_ng; err = rsp_err;
        for (int k = 0; k < hold; k++) begin
            if (k == 1) begin
                cmd_valid = 1'b1; cmd_op = 5'd13; cmd_x = 16'd1; cmd_y = 16'd1;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic [15:0] sweep_exp [18] = '{16'd0, 16'd1, 16'hFFFF, 16'd12, 16'd13, 16'hFFF3,
                                    16'hFFF2, 16'hFFF4, 16'hFFF3, 16'd13, 16'd14, 16'd11,
                                    16'd12, 16'd25, 16'hFFFF, 16'd1, 16'd12, 16'd13};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] d;
        logic        zr, ng, err;
        int          lat;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0;
        rsp_ready = 1'b0; cmp_en = 1'b0;

        // Reset values, with a command offered while reset is held.
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 5'd13; cmd_x = 16'd5; cmd_y = 16'd6;
        @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        check("rst_rsp_zr", {31'd0, rsp_zr}, 32'd0);
        check("rst_rsp_ng", {31'd0, rsp_ng}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        // x - y with 12, 13.
        run_op(5'd14, 16'd12, 16'd13, 0, d, zr, ng, err, lat);
        check("xsuby_data", {16'd0, d}, 32'h0000FFFF);
        check("xsuby_ng", {31'd0, ng}, 32'd1);
        check("xsuby_zr", {31'd0, zr}, 32'd0);
        check("xsuby_err", {31'd0, err}, 32'd0);
        check("xsuby_latency", lat, 32'd2);

        // Sweep all single-cycle opcodes.
        for (int op = 0; op < 18; op++) begin
            run_op(5'(op), 16'd12, 16'd13, 0, d, zr, ng, err, lat);
            check($sformatf("sweep_op%0d_data", op), {16'd0, d}, {16'd0, sweep_exp[op]});
            check($sformatf("sweep_op%0d_lat", op), lat, 32'd2);
        end

        // Multiply: 12*13, wrap to zero, and all-ones squared.
        run_op(5'd18, 16'd12, 16'd13, 0, d, zr, ng, err, lat);
        check("mul_12x13_data", {16'd0, d}, 32'h009C);
        check("mul_12x13_zr", {31'd0, zr}, 32'd0);
        check("mul_12x13_latency", lat, 32'd20);
        run_op(5'd18, 16'h0100, 16'h0100, 0, d, zr, ng, err, lat);
        check("mul_wrap_data", {16'd0, d}, 32'h0000);
        check("mul_wrap_zr", {31'd0, zr}, 32'd1);
        check("mul_wrap_ng", {31'd0, ng}, 32'd0);
        check("mul_wrap_latency", lat, 32'd18);
        run_op(5'd18, 16'hFFFF, 16'hFFFF, 0, d, zr, ng, err, lat);
        check("mul_ones_data", {16'd0, d}, 32'h0001);
        check("mul_ones_latency", lat, 32'd33);

        // Illegal opcode with a stalled response and a stray command pulse.
        run_op(5'd25, 16'd7, 16'd9, 5, d, zr, ng, err, lat);
        check("illegal_data", {16'd0, d}, 32'd0);
        check("illegal_zr", {31'd0, zr}, 32'd1);
        check("illegal_err", {31'd0, err}, 32'd1);
        check("illegal_latency", lat, 32'd2);

        // The stray pulse must not have started a new operation.
        @(negedge clk);
        check("after_hold_idle", {31'd0, cmd_ready}, 32'd1);

        // Reset in the 8th cycle of MUL 12*13.
        @(negedge clk);
        cmd_op = 5'd18; cmd_x = 16'd12; cmd_y = 16'd13; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(5'd13, 16'd3, 16'd4, 0, d, zr, ng, err, lat);
        check("post_reset_add", {16'd0, d}, 32'd7);
        check("post_reset_latency", lat, 32'd2);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
